// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg
//   Shared types and default sizing for the FIR sample sequencer.
//   - seq_state_t : sequencer FSM state encoding
//   - DEF_DATA_W, DEF_FIFO_DEPTH, DEF_ACK_TIMEOUT : default parameter values
package fir_seq_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ACK_TIMEOUT = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLD      = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo
//   Small synchronous FIFO holding samples waiting to be issued to the filter.
//   Ports:
//     clk, n_rst : clock, asynchronous active-low reset (empties the FIFO)
//     push, din  : write request and data; ignored while full
//     pop        : read request; ignored while empty
//     head       : entry at the read pointer (valid when !empty)
//     full,empty : status derived from the pointers
module fir_sample_fifo
  import fir_seq_pkg::*;
#(
  parameter int W     = DEF_DATA_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the index
  // bits match; pointers simply wrap modulo 2*DEPTH.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_sample_sequencer.sv
// fir_sample_sequencer
//   Feeds buffered samples to the fir_filter datapath one at a time and
//   returns each result through a one-entry output register.
//   Ports:
//     clk, n_rst              : clock, asynchronous active-low reset
//     in_valid/in_ready/in_sample : producer side, push into the input FIFO
//     coeff_busy              : coefficient load in progress, blocks new issues
//     modwait, fir_out, err   : status and result from fir_filter
//     sample_data, data_ready : registered sample and one-cycle issue strobe
//     out_valid/out_ready/out_result/out_err : result register to consumer
//     busy                    : FSM active or samples still queued
//
//   Handshakes: a transfer happens on a rising edge where valid && ready are
//   both high; valid, once raised, holds its data stable until that edge, and
//   ready may change freely without affecting valid.
module fir_sample_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sample,
  output logic              in_ready,
  input  logic              coeff_busy,
  input  logic              modwait,
  input  logic [DATA_W-1:0] fir_out,
  input  logic              err,
  output logic [DATA_W-1:0] sample_data,
  output logic              data_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err,
  output logic              busy
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  seq_state_t        state;
  logic [CW-1:0]     wd_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              pop_out;
  logic              can_issue;

  fir_sample_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .din   (in_sample),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign pop_out   = out_valid && out_ready;
  assign can_issue = !fifo_empty && !coeff_busy;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  // A new sample leaves the FIFO only when the result register is free
  // (or being emptied this very edge), which keeps one sample in flight.
  always_comb begin
    fifo_pop = 1'b0;
    case (state)
      ST_IDLE: fifo_pop = can_issue && (!out_valid || pop_out);
      ST_HOLD: fifo_pop = can_issue && pop_out;
      default: fifo_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= ST_IDLE;
      wd_cnt      <= '0;
      sample_data <= '0;
      data_ready  <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_err     <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            sample_data <= fifo_head;
            wd_cnt      <= '0;
            data_ready  <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (modwait) begin
            state <= ST_WAIT_DONE;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
            // This cycle is the ACK_TIMEOUT-th without an acknowledge.
            if (wd_cnt == CW'(ACK_TIMEOUT - 1)) begin
              out_result <= '0;
              out_err    <= 1'b1;
              out_valid  <= 1'b1;
              state      <= ST_HOLD;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (!modwait) begin
            out_result <= fir_out;
            out_err    <= err;
            out_valid  <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (pop_out) begin
            out_valid <= 1'b0;
            if (fifo_pop) begin
              // Back-to-back: next sample issues on the same edge the
              // result is consumed.
              sample_data <= fifo_head;
              wd_cnt      <= '0;
              data_ready  <= 1'b1;
              state       <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// tb_fir_sample_sequencer
//   Directed bench for fir_sample_sequencer with a behavioural filter model:
//   the model answers each data_ready with modwait held for hold_cycles and
//   returns fir_out = sample >> 2, err = sample[15].
module tb_fir_sample_sequencer;

  localparam int W = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid;
  logic [W-1:0]  in_sample;
  logic          in_ready;
  logic          coeff_busy;
  logic          modwait;
  logic [W-1:0]  fir_out;
  logic          err;
  logic [W-1:0]  sample_data;
  logic          data_ready;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_err;
  logic          busy;

  fir_sample_sequencer dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .in_valid    (in_valid),
    .in_sample   (in_sample),
    .in_ready    (in_ready),
    .coeff_busy  (coeff_busy),
    .modwait     (modwait),
    .fir_out     (fir_out),
    .err         (err),
    .sample_data (sample_data),
    .data_ready  (data_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_err     (out_err),
    .busy        (busy)
  );

  // ---------------------------------------------------------------- filter model
  int           hold_cycles = 5;
  bit           never_ack   = 1'b0;
  int           mdl_left;
  logic [W-1:0] mdl_sample;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      modwait    <= 1'b0;
      fir_out    <= '0;
      err        <= 1'b0;
      mdl_left   <= 0;
      mdl_sample <= '0;
    end else if (data_ready && !never_ack) begin
      modwait    <= 1'b1;
      mdl_left   <= hold_cycles - 1;
      mdl_sample <= sample_data;
    end else if (modwait) begin
      if (mdl_left == 0) begin
        modwait <= 1'b0;
        fir_out <= mdl_sample >> 2;
        err     <= mdl_sample[15];
      end else begin
        mdl_left <= mdl_left - 1;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  int         vectors     = 0;
  int         miscompares = 0;
  int         dr_count    = 0;
  logic [W:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (n_rst && data_ready) dr_count++;
  end

  always @(negedge clk) begin
    if (n_rst && data_ready) chk("issue_while_full", {31'b0, out_valid}, 32'd0);
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic push(input logic [W-1:0] d);
    in_valid  = 1'b1;
    in_sample = d;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!out_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic wait_issue(input int max_cycles);
    int n = 0;
    while (!data_ready && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk("issue_timeout", {31'b0, data_ready}, 32'd1);
  endtask

  task automatic pop_result(input string tag);
    logic [W:0] e;
    wait_valid(100);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk({tag, "_result"}, {16'b0, out_result}, {16'b0, e[W-1:0]});
    chk({tag, "_err"}, {31'b0, out_err}, {31'b0, e[W]});
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},    {31'b0, in_ready},    32'd1);
    chk({tag, "_sample_data"}, {16'b0, sample_data}, 32'd0);
    chk({tag, "_data_ready"},  {31'b0, data_ready},  32'd0);
    chk({tag, "_out_valid"},   {31'b0, out_valid},   32'd0);
    chk({tag, "_out_result"},  {16'b0, out_result},  32'd0);
    chk({tag, "_out_err"},     {31'b0, out_err},     32'd0);
    chk({tag, "_busy"},        {31'b0, busy},        32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [W-1:0] fill_v [5];
  logic         fill_rdy [5];
  int           d0;
  int           n;
  bit           ov_seen;

  initial begin
    in_valid   = 1'b0;
    in_sample  = '0;
    coeff_busy = 1'b0;
    out_ready  = 1'b0;
    n_rst      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    n_rst = 1'b1;
    @(negedge clk);

    // Single sample: issue two edges after the push edge, result 7 cycles later.
    hold_cycles = 5;
    push(16'h0100);
    chk("t1_no_early_issue", {31'b0, data_ready}, 32'd0);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_issue", {31'b0, data_ready}, 32'd1);
    chk("t1_sample", {16'b0, sample_data}, 32'h0100);
    exp_q.push_back({1'b0, 16'h0040});
    repeat (6) @(negedge clk);
    chk("t1_not_yet_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("t1_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_one_issue", dr_count, 32'd1);
    pop_result("t1");
    chk("t1_idle", {31'b0, busy}, 32'd0);
    chk("t1_sample_held", {16'b0, sample_data}, 32'h0100);

    // Fill: issue blocked, four entries fit, the fifth is refused.
    coeff_busy  = 1'b1;
    hold_cycles = 3;
    fill_v   = '{16'h0100, 16'h0200, 16'h0400, 16'h8004, 16'h1234};
    fill_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      push(fill_v[i]);
      chk($sformatf("t2_in_ready_%0d", i), {31'b0, in_ready}, {31'b0, fill_rdy[i]});
    end
    exp_q.push_back({1'b0, 16'h0040});
    exp_q.push_back({1'b0, 16'h0080});
    exp_q.push_back({1'b0, 16'h0100});
    exp_q.push_back({1'b1, 16'h2001});
    coeff_busy = 1'b0;
    for (int i = 0; i < 4; i++) pop_result($sformatf("t2_%0d", i));
    repeat (10) @(negedge clk);
    chk("t2_no_fifth", {31'b0, out_valid}, 32'd0);
    chk("t2_idle", {31'b0, busy}, 32'd0);

    // Output backpressure: no new issue until the pop, then back-to-back.
    hold_cycles = 2;
    push(16'h0800);
    push(16'h0C00);
    exp_q.push_back({1'b0, 16'h0200});
    exp_q.push_back({1'b0, 16'h0300});
    wait_valid(50);
    d0 = dr_count;
    repeat (10) @(negedge clk);
    chk("t3_no_issue", dr_count, d0);
    chk("t3_held", {31'b0, out_valid}, 32'd1);
    pop_result("t3a");
    chk("t3_b2b_issue", {31'b0, data_ready}, 32'd1);
    chk("t3_b2b_sample", {16'b0, sample_data}, 32'h0C00);
    pop_result("t3b");

    // Coefficient load holds off issue; resumes on the next cycle.
    coeff_busy = 1'b1;
    push(16'h1000);
    push(16'h2000);
    exp_q.push_back({1'b0, 16'h0400});
    exp_q.push_back({1'b0, 16'h0800});
    d0 = dr_count;
    repeat (8) @(negedge clk);
    chk("t4_blocked", dr_count, d0);
    chk("t4_busy", {31'b0, busy}, 32'd1);
    coeff_busy = 1'b0;
    @(negedge clk);
    chk("t4_resume", {31'b0, data_ready}, 32'd1);
    pop_result("t4a");
    pop_result("t4b");

    // Watchdog: no acknowledge -> error result after 4 WAIT_ACK cycles.
    never_ack = 1'b1;
    push(16'h0300);
    wait_issue(10);
    repeat (4) @(negedge clk);
    chk("t5_not_yet_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("t5_timeout_valid", {31'b0, out_valid}, 32'd1);
    exp_q.push_back({1'b1, 16'h0000});
    pop_result("t5_wd");
    never_ack   = 1'b0;
    hold_cycles = 4;
    push(16'h0040);
    exp_q.push_back({1'b0, 16'h0010});
    pop_result("t5_next");

    // Reset during WAIT_DONE with three samples queued.
    hold_cycles = 30;
    push(16'h0100);
    push(16'h0200);
    push(16'h0300);
    push(16'h0400);
    n = 0;
    while (!modwait && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_filter_busy", {31'b0, modwait}, 32'd1);
    repeat (3) @(negedge clk);
    #1 n_rst = 1'b0;
    #1 check_reset_values("t6_rst");
    d0 = dr_count;
    repeat (2) @(negedge clk);
    n_rst   = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ov_seen = ov_seen | out_valid;
    end
    chk("t6_no_stale_result", {31'b0, ov_seen}, 32'd0);
    chk("t6_no_issue", dr_count, d0);
    chk("t6_idle", {31'b0, busy}, 32'd0);
    chk("t6_in_ready", {31'b0, in_ready}, 32'd1);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
